// File: rtl/load_unit_sized_if.sv
// Wishbone master/slave bundle used by the load unit (wb_bus_t).
// The master drives address/select/strobe/cycle/lock; the slave returns data, ack and grant.
interface wb_bus_t;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_lock;
  logic        wb_we;
  logic [31:0] wb_dat_ms;
  logic [3:0]  wb_tgd_ms;
  logic [3:0]  wb_tgc;
  logic [3:0]  wb_tga;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic        wb_gnt;

  modport master (
    output wb_adr, wb_sel, wb_stb, wb_cyc, wb_lock, wb_we,
    output wb_dat_ms, wb_tgd_ms, wb_tgc, wb_tga,
    input  wb_dat_sm, wb_ack, wb_gnt
  );

  modport slave (
    input  wb_adr, wb_sel, wb_stb, wb_cyc, wb_lock, wb_we,
    input  wb_dat_ms, wb_tgd_ms, wb_tgc, wb_tga,
    output wb_dat_sm, wb_ack, wb_gnt
  );
endinterface

// File: rtl/load_unit_sized.sv
// Wishbone load master: byte/half/word loads with sign/zero extension, optional two-beat
// split of word-crossing accesses, and a per-beat bus watchdog.
module load_unit_sized #(
  parameter bit          MISALIGNED_EN = 1'b1,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [31:0]  addr_i,
  input  logic [1:0]   size_i,
  input  logic         unsigned_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [31:0]  data_o,
  output logic         err_o,
  wb_bus_t.master      wb_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int unsigned WD_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Bytes are taken from lane 'off' of the first word onward, spilling into the second word.
  function automatic logic [31:0] assemble(input logic [31:0] lo_word, input logic [31:0] hi_word,
                                           input logic [1:0] off, input logic [1:0] size,
                                           input logic uns);
    logic [63:0] cat;
    cat = {hi_word, lo_word} >> {off, 3'b000};
    case (size)
      2'b00:   assemble = uns ? {24'h000000, cat[7:0]}  : {{24{cat[7]}}, cat[7:0]};
      2'b01:   assemble = uns ? {16'h0000, cat[15:0]}   : {{16{cat[15]}}, cat[15:0]};
      default: assemble = cat[31:0];
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       beat0_q, beat0_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [7:0]        sel_span_s;
  logic              split_s;
  logic              in_beat_s;
  logic              stb_s;
  logic              done_s;
  logic [WD_W-1:0]   wd_inc_s;
  logic              expire_s;
  logic              misalign_in_s;
  logic              reject_s;
  logic [31:0]       word_adr_s;

  // Lanes touched across both words; anything in the upper nibble needs a second beat.
  assign sel_span_s    = {4'b0000, size_mask(size_q)} << addr_q[1:0];
  assign split_s       = |sel_span_s[7:4];
  assign in_beat_s     = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign stb_s         = in_beat_s && wb_bus.wb_gnt;
  assign done_s        = stb_s && wb_bus.wb_ack;
  assign wd_inc_s      = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
  assign expire_s      = (TIMEOUT != 32'd0) && (32'(wd_inc_s) == TIMEOUT);
  assign misalign_in_s = ((size_i == 2'b01) && addr_i[0]) ||
                         ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
  assign reject_s      = (size_i == 2'b11) || (!MISALIGNED_EN && misalign_in_s);
  assign word_adr_s    = {addr_q[31:2], 2'b00};

  assign wb_bus.wb_cyc    = in_beat_s;
  assign wb_bus.wb_stb    = stb_s;
  assign wb_bus.wb_lock   = in_beat_s && split_s;
  assign wb_bus.wb_adr    = (state_q == S_BEAT1) ? (word_adr_s + 32'd4) : word_adr_s;
  assign wb_bus.wb_sel    = !stb_s ? 4'b0000 :
                            (state_q == S_BEAT1) ? sel_span_s[7:4] : sel_span_s[3:0];
  assign wb_bus.wb_we     = 1'b0;
  assign wb_bus.wb_dat_ms = 32'h0000_0000;
  assign wb_bus.wb_tgd_ms = 4'h0;
  assign wb_bus.wb_tgc    = 4'h0;
  assign wb_bus.wb_tga    = 4'h0;

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

  // Next-state and response logic of the load sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    beat0_d = beat0_q;
    wd_d    = wd_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d = addr_i;
          size_d = size_i;
          uns_d  = unsigned_i;
          wd_d   = {WD_W{1'b0}};
          if (reject_s) begin
            state_d = S_RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            data_d  = 32'h0000_0000;
          end else begin
            state_d = S_BEAT0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BEAT0: begin
        if (done_s) begin
          beat0_d = wb_bus.wb_dat_sm;
          wd_d    = {WD_W{1'b0}};
          if (split_s) begin
            state_d = S_BEAT1;
          end else begin
            state_d = S_RESP;
            valid_d = 1'b1;
            err_d   = 1'b0;
            data_d  = assemble(wb_bus.wb_dat_sm, 32'h0000_0000, addr_q[1:0], size_q, uns_q);
          end
        end else if (expire_s) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = 1'b1;
          data_d  = 32'h0000_0000;
        end else begin
          wd_d = wd_inc_s;
        end
      end
      S_BEAT1: begin
        if (done_s) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = 1'b0;
          data_d  = assemble(beat0_q, wb_bus.wb_dat_sm, addr_q[1:0], size_q, uns_q);
        end else if (expire_s) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = 1'b1;
          data_d  = 32'h0000_0000;
        end else begin
          wd_d = wd_inc_s;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      beat0_q <= 32'h0000_0000;
      wd_q    <= {WD_W{1'b0}};
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      beat0_q <= beat0_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_unit_sized.sv
// Bench for load_unit_sized: directed scenarios plus randomized loads against a byte-level
// memory model; dut_a splits misaligned loads with an 8-cycle watchdog, dut_b rejects them.
module tb_load_unit_sized;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, req_i, unsigned_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
  logic [31:0] data_a, data_b;
  logic        gnt_s, ack_s;
  logic [31:0] dat_s;

  wb_bus_t bus_a();
  wb_bus_t bus_b();
  assign bus_a.wb_gnt = gnt_s;
  assign bus_a.wb_ack = ack_s;
  assign bus_a.wb_dat_sm = dat_s;
  assign bus_b.wb_gnt = gnt_s;
  assign bus_b.wb_ack = ack_s;
  assign bus_b.wb_dat_sm = dat_s;

  load_unit_sized #(.MISALIGNED_EN(1'b1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .ready_o(ready_a), .valid_o(valid_a), .data_o(data_a),
    .err_o(err_a), .wb_bus(bus_a));

  load_unit_sized #(.MISALIGNED_EN(1'b0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .ready_o(ready_b), .valid_o(valid_b), .data_o(data_b),
    .err_o(err_b), .wb_bus(bus_b));

  int n_pass = 0;
  int n_total = 0;
  int mode = 0;   // 0 immediate gnt+ack, 1 random with bounded wait, 2 never grant
  int miss = 0;
  int cyc_a_cnt = 0;
  int cyc_b_cnt = 0;
  logic [31:0] mem [int unsigned];
  logic [36:0] beat_q [$];

  function automatic logic [31:0] word_at(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    else return (w * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Reference: gather bytes one address at a time, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] v, a, wv;
    logic [7:0]  b;
    int n;
    n = nbytes(size);
    v = 32'h0;
    b = 8'h00;
    for (int i = 0; i < n; i++) begin
      a  = addr + i;
      wv = word_at({a[31:2], 2'b00});
      b  = wv[8*a[1:0] +: 8];
      v  = v | ({24'h0, b} << (8*i));
    end
    if (!uns && n < 4 && b[7]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Slave: decide grant/ack and return the word for the current address.
  always begin
    @(posedge clk);
    #1;
    case (mode)
      0: begin gnt_s = 1'b1; ack_s = 1'b1; end
      1: begin
        if (miss >= 3) begin gnt_s = 1'b1; ack_s = 1'b1; end
        else begin
          gnt_s = ($urandom_range(0, 3) != 0);
          ack_s = ($urandom_range(0, 2) != 0);
        end
      end
      2: begin gnt_s = 1'b0; ack_s = ($urandom_range(0, 1) != 0); end
      default: begin gnt_s = 1'b0; ack_s = 1'b0; end
    endcase
    dat_s = word_at(bus_a.wb_adr);
  end

  // Monitor: record completed beats and count cycles with wb_cyc asserted.
  always @(negedge clk) begin
    if (bus_a.wb_stb && bus_a.wb_ack)
      beat_q.push_back({bus_a.wb_lock, bus_a.wb_sel, bus_a.wb_adr});
    if (bus_a.wb_cyc) cyc_a_cnt++;
    if (bus_b.wb_cyc) cyc_b_cnt++;
    if (bus_a.wb_cyc && !(bus_a.wb_stb && bus_a.wb_ack)) miss++;
    else miss = 0;
  end

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         output int k_a, output logic [31:0] d_a, output logic e_a,
                         output int k_b, output logic [31:0] d_b, output logic e_b);
    k_a = -1; k_b = -1; d_a = 32'h0; d_b = 32'h0; e_a = 1'b0; e_b = 1'b0;
    @(negedge clk);
    addr_i = addr; size_i = size; unsigned_i = uns; req_i = 1'b1;
    beat_q.delete();
    cyc_a_cnt = 0;
    cyc_b_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    for (int lat = 0; lat < 40 && k_a < 0; lat++) begin
      if (lat > 0) @(negedge clk);
      if (valid_b && k_b < 0) begin k_b = lat + 1; d_b = data_b; e_b = err_b; end
      if (valid_a) begin k_a = lat + 1; d_a = data_a; e_a = err_a; end
    end
    if (k_a < 0) chk("valid_a_seen", {31'h0, valid_a}, 32'h1);
    else begin
      @(negedge clk);
      chk("valid_pulse", {31'h0, valid_a}, 32'h0);
      chk("ready_back", {31'h0, ready_a}, 32'h1);
    end
  endtask

  // Expected beats derived from which word each byte of the access falls in.
  task automatic check_beats(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] w0, a;
    logic [3:0]  sel0, sel1;
    logic [36:0] e;
    int nb;
    w0 = {addr[31:2], 2'b00};
    sel0 = 4'b0000;
    sel1 = 4'b0000;
    for (int i = 0; i < nbytes(size); i++) begin
      a = addr + i;
      if ({a[31:2], 2'b00} == w0) sel0[a[1:0]] = 1'b1;
      else sel1[a[1:0]] = 1'b1;
    end
    nb = (sel1 != 4'b0000) ? 2 : 1;
    chk("n_beats", beat_q.size(), nb);
    if (beat_q.size() >= 1) begin
      e = beat_q[0];
      chk("beat0_adr", e[31:0], w0);
      chk("beat0_sel", {28'h0, e[35:32]}, {28'h0, sel0});
      chk("beat0_lock", {31'h0, e[36]}, (nb == 2) ? 32'h1 : 32'h0);
    end
    if (nb == 2 && beat_q.size() >= 2) begin
      e = beat_q[1];
      chk("beat1_adr", e[31:0], w0 + 32'd4);
      chk("beat1_sel", {28'h0, e[35:32]}, {28'h0, sel1});
      chk("beat1_lock", {31'h0, e[36]}, 32'h1);
    end
  endtask

  initial begin
    int k_a, k_b, seen;
    logic [31:0] d_a, d_b, addr, exp_d;
    logic e_a, e_b, uns, misal;
    logic [1:0] size;

    rst_i = 1'b1; req_i = 1'b0; addr_i = 32'h0; size_i = 2'b00; unsigned_i = 1'b0;
    gnt_s = 1'b0; ack_s = 1'b0; dat_s = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, ready_a}, 32'h1);
    chk("rst_valid", {31'h0, valid_a}, 32'h0);
    chk("rst_data", data_a, 32'h0);
    chk("rst_err", {31'h0, err_a}, 32'h0);
    chk("rst_cyc", {31'h0, bus_a.wb_cyc}, 32'h0);
    chk("rst_stb", {31'h0, bus_a.wb_stb}, 32'h0);
    chk("rst_lock", {31'h0, bus_a.wb_lock}, 32'h0);
    chk("rst_sel", {28'h0, bus_a.wb_sel}, 32'h0);
    rst_i = 1'b0;

    // Aligned word, immediate grant.
    mem[32'h100] = 32'hDEAD_BEEF;
    do_load(32'h100, 2'b10, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lw_lat", k_a, 32'd2);
    chk("lw_data", d_a, 32'hDEAD_BEEF);
    chk("lw_err", {31'h0, e_a}, 32'h0);
    check_beats(32'h100, 2'b10);
    chk("lw_b_lat", k_b, 32'd2);
    chk("lw_b_data", d_b, 32'hDEAD_BEEF);

    // Byte at the top lane, signed and unsigned.
    mem[32'h100] = 32'h8011_2233;
    do_load(32'h103, 2'b00, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lb_data", d_a, 32'hFFFF_FF80);
    check_beats(32'h103, 2'b00);
    do_load(32'h103, 2'b00, 1'b1, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lbu_data", d_a, 32'h0000_0080);
    chk("lbu_lat", k_a, 32'd2);

    // Half crossing a word boundary.
    mem[32'h100] = 32'hAB00_0000;
    mem[32'h104] = 32'h0000_00CD;
    do_load(32'h103, 2'b01, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lh_split_data", d_a, 32'hFFFF_CDAB);
    chk("lh_split_lat", k_a, 32'd3);
    chk("lh_split_err", {31'h0, e_a}, 32'h0);
    check_beats(32'h103, 2'b01);
    chk("lh_b_lat", k_b, 32'd1);
    chk("lh_b_err", {31'h0, e_b}, 32'h1);
    chk("lh_b_nocyc", cyc_b_cnt, 32'd0);
    do_load(32'h103, 2'b01, 1'b1, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lhu_split_data", d_a, 32'h0000_CDAB);

    // Misaligned word: split on A, rejected on B without a bus cycle.
    do_load(32'h102, 2'b10, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("lw102_data", d_a, ref_load(32'h102, 2'b10, 1'b0));
    chk("lw102_b_lat", k_b, 32'd1);
    chk("lw102_b_err", {31'h0, e_b}, 32'h1);
    chk("lw102_b_data", d_b, 32'h0);
    chk("lw102_b_nocyc", cyc_b_cnt, 32'd0);

    // Illegal size.
    do_load(32'h100, 2'b11, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("ill_lat", k_a, 32'd1);
    chk("ill_err", {31'h0, e_a}, 32'h1);
    chk("ill_data", d_a, 32'h0);
    chk("ill_nocyc", cyc_a_cnt, 32'd0);

    // Randomized loads with random grant/ack timing, including address wrap.
    mode = 1;
    for (int it = 0; it < 60; it++) begin
      addr  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : 32'h0000_1000) + $urandom_range(0, 31);
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      misal = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
      do_load(addr, size, uns, k_a, d_a, e_a, k_b, d_b, e_b);
      if (size == 2'b11) begin
        chk("rnd_ill_err", {31'h0, e_a}, 32'h1);
        chk("rnd_ill_data", d_a, 32'h0);
        chk("rnd_ill_lat", k_a, 32'd1);
      end else begin
        exp_d = ref_load(addr, size, uns);
        chk("rnd_data", d_a, exp_d);
        chk("rnd_err", {31'h0, e_a}, 32'h0);
        check_beats(addr, size);
      end
      if (size == 2'b11 || misal) begin
        chk("rnd_b_err", {31'h0, e_b}, 32'h1);
        chk("rnd_b_lat", k_b, 32'd1);
      end else begin
        chk("rnd_b_data", d_b, exp_d);
        chk("rnd_b_lat", k_b, k_a);
      end
    end

    // Watchdog: no grant ever.
    mode = 2;
    do_load(32'h300, 2'b10, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("wd_cyc_cycles", cyc_a_cnt, 32'd8);
    chk("wd_err", {31'h0, e_a}, 32'h1);
    chk("wd_data", d_a, 32'h0);
    chk("wd_lat", k_a, 32'd9);
    chk("wd_b_still_busy", {31'h0, bus_b.wb_cyc}, 32'h1);

    @(negedge clk); rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    chk("rst2_b_ready", {31'h0, ready_b}, 32'h1);
    chk("rst2_b_cyc", {31'h0, bus_b.wb_cyc}, 32'h0);

    // Reset while the second beat of a split load is pending.
    mode = 0;
    @(negedge clk);
    addr_i = 32'h103; size_i = 2'b01; unsigned_i = 1'b0; req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    mode = 2;
    @(negedge clk);
    chk("b1_cyc", {31'h0, bus_a.wb_cyc}, 32'h1);
    chk("b1_lock", {31'h0, bus_a.wb_lock}, 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("b1rst_cyc", {31'h0, bus_a.wb_cyc}, 32'h0);
    chk("b1rst_lock", {31'h0, bus_a.wb_lock}, 32'h0);
    chk("b1rst_valid", {31'h0, valid_a}, 32'h0);
    chk("b1rst_ready", {31'h0, ready_a}, 32'h1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_a) seen++;
    end
    chk("b1rst_no_valid", seen, 32'd0);

    mode = 0;
    mem[32'h200] = 32'h1234_5678;
    do_load(32'h200, 2'b10, 1'b0, k_a, d_a, e_a, k_b, d_b, e_b);
    chk("post_rst_data", d_a, 32'h1234_5678);
    chk("post_rst_lat", k_a, 32'd2);
    chk("post_rst_err", {31'h0, e_a}, 32'h0);
    check_beats(32'h200, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
